test_result_monitor: RTL and testbench

Synthesizable self-check monitor for riscv-tests runs. It snoops the CPU register-file write-back port and keeps shadow copies of the done, pass and test-number registers. After a configurable settle window it reports pass, fail or timeout. It sits beside `risc_v_top` in `risc_v_cpu` and generalises the bench-only x26/x27 check so FPGA builds and any testbench share one verdict source.

---
 rtl/test_result_monitor.sv | 111 +++++++++++
 tb/tb_test_result_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/test_result_monitor.sv
// test_result_monitor: shadows the riscv-tests done/pass/number registers from the write-back port and reports pass, fail or timeout.
// Define TEST_MON_TIMEOUT_EN to compile in the RUN-state timeout; otherwise timeout is tied to 0.
module test_result_monitor #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int NUM_REG        = 3,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              clear,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-1:0] fail_num,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [1:0]        r_state;
    logic [SW-1:0]     r_settle;
    logic [DATA_W-1:0] r_sh_done, r_sh_pass, r_sh_num, r_fail_num;
    logic [CNT_W-1:0]  r_cycle;
    logic              r_done, r_pass, r_fail, r_timeout;
    logic              w_wr, w_trig, w_ok, w_to_hit;

    assign w_wr   = wb_en && wb_addr != '0 && r_state != S_DONE;
    assign w_trig = r_sh_done == DATA_W'(1) || r_sh_pass == DATA_W'(1);
    assign w_ok   = r_sh_done == DATA_W'(1) && r_sh_pass == DATA_W'(1);
`ifdef TEST_MON_TIMEOUT_EN
    assign w_to_hit = r_cycle == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    // Constant-false AND folds the comparator away while keeping the parameter referenced.
    assign w_to_hit = 1'b0 && (r_cycle == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_settle   <= '0;
            r_sh_done  <= '0;
            r_sh_pass  <= '0;
            r_sh_num   <= '0;
            r_fail_num <= '0;
            r_cycle    <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (clear) begin
            r_state    <= S_RUN;
            r_settle   <= '0;
            r_sh_done  <= '0;
            r_sh_pass  <= '0;
            r_sh_num   <= '0;
            r_fail_num <= '0;
            r_cycle    <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_wr && wb_addr == ADDR_W'(DONE_REG)) r_sh_done <= wb_data;
            if (w_wr && wb_addr == ADDR_W'(PASS_REG)) r_sh_pass <= wb_data;
            if (w_wr && wb_addr == ADDR_W'(NUM_REG))  r_sh_num  <= wb_data;
            if (r_state != S_DONE && r_cycle != '1) r_cycle <= r_cycle + CNT_W'(1);
            case (r_state)
                S_RUN: begin
                    if (w_trig) begin
                        r_state  <= S_SETTLE;
                        r_settle <= SW'(SETTLE_CYCLES - 1);
                    end else if (w_to_hit) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_pass     <= w_ok;
                        r_fail     <= !w_ok;
                        r_fail_num <= r_sh_num;
                    end else begin
                        r_settle <= r_settle - SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign fail_num    = r_fail_num;
    assign cycle_count = r_cycle;
endmodule

// File: tb/tb_test_result_monitor.sv
// tb_test_result_monitor: directed and randomized checks of test_result_monitor against an episode-level reference model.
module tb_test_result_monitor;
    localparam int S = 10;
    localparam int T = 50;
    localparam int L = 70;
`ifdef TEST_MON_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, wb_en = 1'b0, clear = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_num, cycle_count;
    logic        z_done, z_pass, z_fail, z_timeout;
    logic [31:0] z_fail_num, z_cycle_count;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    test_result_monitor #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .clear(clear), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_num(fail_num), .cycle_count(cycle_count)
    );

    test_result_monitor #(.DONE_REG(0), .SETTLE_CYCLES(S)) dut_z (
        .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .clear(clear), .done(z_done), .pass(z_pass), .fail(z_fail), .timeout(z_timeout),
        .fail_num(z_fail_num), .cycle_count(z_cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en = en;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        wb_addr = '0;
        wb_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 32'd0);
    endtask

    task automatic rearm();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    logic        we [L+1];
    logic [4:0]  wa [L+1];
    logic [31:0] wd [L+1];
    logic [31:0] sd, sp, sn, num;
    int          trig, v, k;
    bit          ep_pass, ep_to;
    logic [4:0]  addrs [5];

    initial begin
        addrs = '{5'd0, 5'd3, 5'd26, 5'd27, 5'd9};
        #23 rst_n = 1'b1;
        #1;
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_fail", fail, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_fail_num", fail_num, 0);
        chk("reset_cycle", cycle_count, 0);
        @(posedge clk);
        #1;

        rearm();
        step(1'b1, 5'd27, 32'd1);
        idle(1);
        step(1'b1, 5'd26, 32'd1);
        idle(8);
        chk("pass_early_done", done, 0);
        idle(1);
        chk("pass_done", done, 1);
        chk("pass_pass", pass, 1);
        chk("pass_fail", fail, 0);
        chk("pass_timeout", timeout, 0);
        chk("pass_cycle", cycle_count, 12);

        rearm();
        step(1'b1, 5'd3, 32'h1d);
        step(1'b1, 5'd27, 32'd1);
        idle(10);
        chk("fail_early_done", done, 0);
        idle(1);
        chk("fail_done", done, 1);
        chk("fail_fail", fail, 1);
        chk("fail_pass", pass, 0);
        chk("fail_num", fail_num, 32'h1d);

        rearm();
`ifdef TEST_MON_TIMEOUT_EN
        idle(T - 1);
        chk("to_early_done", done, 0);
        idle(1);
        chk("to_done", done, 1);
        chk("to_timeout", timeout, 1);
        chk("to_pass", pass, 0);
        chk("to_cycle", cycle_count, T);
`else
        idle(1000);
        chk("noto_done", done, 0);
        chk("noto_timeout", timeout, 0);
        chk("noto_cycle", cycle_count, 1000);
`endif

        rearm();
        step(1'b1, 5'd0, 32'd1);
        step(1'b1, 5'd26, 32'd3);
        idle(98);
        chk("x0_done", z_done, 0);
        chk("x0_cycle", z_cycle_count, 100);
        chk("non1_pass", pass, 0);
        chk("non1_fail", fail, 0);
        chk("non1_timeout", timeout, TO);

        rearm();
        step(1'b1, 5'd26, 32'd1);
        idle(4);
        step(1'b1, 5'd27, 32'd1);
        idle(5);
        chk("late_early_done", done, 0);
        idle(1);
        chk("late_done", done, 1);
        chk("late_pass", pass, 1);
        chk("late_fail", fail, 0);
        rearm();
        chk("clear_done", done, 0);
        chk("clear_pass", pass, 0);
        chk("clear_cycle", cycle_count, 0);
        idle(15);
        chk("clear_shadow_done", done, 0);
        chk("clear_shadow_cycle", cycle_count, 15);

        rearm();
        step(1'b1, 5'd26, 32'd1);
        idle(4);
        chk("rst_pre_cycle", cycle_count, 5);
        rst_n = 1'b0;
        #1;
        chk("rst_cycle", cycle_count, 0);
        chk("rst_done", done, 0);
        chk("rst_fail_num", fail_num, 0);
        #1 rst_n = 1'b1;
        idle(20);
        chk("rst_after_done", done, 0);
        chk("rst_after_cycle", cycle_count, 20);

        for (int ep = 0; ep < 20; ep++) begin
            for (int e = 1; e <= L; e++) begin
                we[e] = e <= 30 && $urandom_range(0, 3) == 0;
                wa[e] = addrs[$urandom_range(0, 4)];
                k = $urandom_range(0, 3);
                wd[e] = k == 2 ? 32'd0 : k == 3 ? ($urandom | 32'h100) : 32'd1;
            end
            sd = 0; sp = 0; sn = 0; num = 0;
            trig = 0; v = 0; ep_pass = 0; ep_to = 0;
            for (int e = 1; e <= L && v == 0; e++) begin
                if (trig == 0 && (sd == 1 || sp == 1)) trig = e;
                else if (trig == 0 && TO && e == T) begin
                    v = e;
                    ep_to = 1;
                end
                if (trig != 0 && e == trig + S) begin
                    v = e;
                    ep_pass = sd == 1 && sp == 1;
                    num = sn;
                end
                if (we[e] && wa[e] == 26) sd = wd[e];
                if (we[e] && wa[e] == 27) sp = wd[e];
                if (we[e] && wa[e] == 3) sn = wd[e];
            end
            rearm();
            for (int e = 1; e <= L; e++) step(we[e], wa[e], wd[e]);
            chk($sformatf("rnd%0d_done", ep), done, v != 0);
            chk($sformatf("rnd%0d_pass", ep), pass, ep_pass);
            chk($sformatf("rnd%0d_fail", ep), fail, v != 0 && !ep_to && !ep_pass);
            chk($sformatf("rnd%0d_timeout", ep), timeout, ep_to);
            chk($sformatf("rnd%0d_fail_num", ep), fail_num, num);
            chk($sformatf("rnd%0d_cycle", ep), cycle_count, v != 0 ? v : L);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
